// File: rtl/fifo_pkg.sv
// Shared types and helpers for the thresholded synchronous FIFO.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Occupancy must represent 0..DEPTH inclusive, hence one extra bit.
    function automatic int cnt_w(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: one synchronous write port, one asynchronous read port, no reset.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_array [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_array[waddr] <= wdata;
        end
    end

    assign rdata = mem_array[raddr];

endmodule

// File: rtl/fifo_sync_thresh.sv
// Single-clock FIFO with occupancy count, programmable almost flags,
// overflow/underflow pulses and selectable standard or first-word-fall-through read.
module fifo_sync_thresh
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 4,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int         DEPTH = 1 << ADDR_WIDTH;
    localparam int         CW    = cnt_w(ADDR_WIDTH);
    localparam fifo_mode_e MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [ADDR_WIDTH:0] ptr_t;

    localparam cnt_t CNT_ONE     = cnt_t'(1);
    localparam ptr_t PTR_ONE     = ptr_t'(1);
    localparam cnt_t CNT_DEPTH   = cnt_t'(DEPTH);
    localparam cnt_t CNT_AFULL   = cnt_t'(AFULL_THRESH);
    localparam cnt_t CNT_AEMPTY  = cnt_t'(AEMPTY_THRESH);

    if (ADDR_WIDTH < 1) begin : g_bad_addr_width
        $error("fifo_sync_thresh: ADDR_WIDTH must be >= 1");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("fifo_sync_thresh: AFULL_THRESH must be in 1..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
        $error("fifo_sync_thresh: AEMPTY_THRESH must be in 0..DEPTH-1");
    end

    ptr_t wr_ptr_bin;
    ptr_t rd_ptr_bin;
    cnt_t count_reg;
    logic overflow_reg;
    logic underflow_reg;

    logic                  full_flag;
    logic                  empty_flag;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // Flags come only from registered count so no request input reaches an output.
    assign full_flag    = (count_reg == CNT_DEPTH);
    assign empty_flag   = (count_reg == '0);
    assign full         = full_flag;
    assign empty        = empty_flag;
    assign almost_full  = (count_reg >= CNT_AFULL);
    assign almost_empty = (count_reg <= CNT_AEMPTY);
    assign count        = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

    assign wr_acc = wr_en && !full_flag;
    assign rd_acc = rd_en && !empty_flag;

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_bin[ADDR_WIDTH-1:0]),
        .wdata (din),
        .raddr (rd_ptr_bin[ADDR_WIDTH-1:0]),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_bin    <= '0;
            rd_ptr_bin    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr_bin <= wr_ptr_bin + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr_bin <= rd_ptr_bin + PTR_ONE;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
            overflow_reg  <= wr_en && full_flag;
            underflow_reg <= rd_en && empty_flag;
        end
    end

    if (MODE == FIFO_FWFT) begin : g_fwft
        // Head word is presented combinationally from the array while data is held.
        assign dout       = empty_flag ? '0 : mem_rdata;
        assign dout_valid = !empty_flag;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] dout_reg;
        logic                  dout_valid_reg;

        always_ff @(posedge clk) begin
            if (rst) begin
                dout_reg       <= '0;
                dout_valid_reg <= 1'b0;
            end else begin
                dout_valid_reg <= rd_acc;
                if (rd_acc) begin
                    dout_reg <= mem_rdata;
                end
            end
        end

        assign dout       = dout_reg;
        assign dout_valid = dout_valid_reg;
    end

endmodule

// File: tb/tb_fifo_sync_thresh.sv
// Randomised bench driving a standard-mode and an FWFT-mode FIFO in lockstep
// against a queue-based reference model.
module tb_fifo_sync_thresh;

    localparam int DW     = 8;
    localparam int AW     = 4;
    localparam int DEPTH  = 16;
    localparam int AFULL  = 14;
    localparam int AEMPTY = 2;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] din;

    logic [DW-1:0] s_dout, f_dout;
    logic          s_valid, f_valid;
    logic          s_full, f_full, s_empty, f_empty;
    logic          s_afull, f_afull, s_aempty, f_aempty;
    logic [AW:0]   s_count, f_count;
    logic          s_ovf, f_ovf, s_unf, f_unf;

    fifo_sync_thresh #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0),
        .AFULL_THRESH(AFULL), .AEMPTY_THRESH(AEMPTY)
    ) dut_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(s_dout), .dout_valid(s_valid), .full(s_full), .empty(s_empty),
        .almost_full(s_afull), .almost_empty(s_aempty), .count(s_count),
        .overflow(s_ovf), .underflow(s_unf)
    );

    fifo_sync_thresh #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1),
        .AFULL_THRESH(AFULL), .AEMPTY_THRESH(AEMPTY)
    ) dut_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(f_dout), .dout_valid(f_valid), .full(f_full), .empty(f_empty),
        .almost_full(f_afull), .almost_empty(f_aempty), .count(f_count),
        .overflow(f_ovf), .underflow(f_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    int            txn    = 0;
    logic [DW-1:0] model_q [$];
    int            wr_total = 0;
    int            rd_total = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (txn %0d)", tag, got, exp, txn);
        end
    endtask

    // Compare every observable output of both instances against model expectations.
    task automatic check_all(input bit exp_ovf, input bit exp_unf,
                             input bit exp_svalid, input logic [DW-1:0] exp_sdout);
        int n;
        n = model_q.size();
        check_eq("count_std",  32'(s_count),  32'(n));
        check_eq("count_fwft", 32'(f_count),  32'(n));
        check_eq("full_std",   32'(s_full),   32'(n == DEPTH));
        check_eq("full_fwft",  32'(f_full),   32'(n == DEPTH));
        check_eq("empty_std",  32'(s_empty),  32'(n == 0));
        check_eq("empty_fwft", 32'(f_empty),  32'(n == 0));
        check_eq("afull_std",  32'(s_afull),  32'(n >= AFULL));
        check_eq("afull_fwft", 32'(f_afull),  32'(n >= AFULL));
        check_eq("aempty_std", 32'(s_aempty), 32'(n <= AEMPTY));
        check_eq("aempty_fwft",32'(f_aempty), 32'(n <= AEMPTY));
        check_eq("ovf_std",    32'(s_ovf),    32'(exp_ovf));
        check_eq("ovf_fwft",   32'(f_ovf),    32'(exp_ovf));
        check_eq("unf_std",    32'(s_unf),    32'(exp_unf));
        check_eq("unf_fwft",   32'(f_unf),    32'(exp_unf));
        check_eq("valid_std",  32'(s_valid),  32'(exp_svalid));
        if (exp_svalid) check_eq("dout_std", 32'(s_dout), 32'(exp_sdout));
        check_eq("valid_fwft", 32'(f_valid),  32'(n != 0));
        if (n != 0) check_eq("dout_fwft", 32'(f_dout), 32'(model_q[0]));
        check_eq("wr_ptr", 32'(dut_std.wr_ptr_bin), 32'(wr_total % (2 * DEPTH)));
        check_eq("rd_ptr", 32'(dut_std.rd_ptr_bin), 32'(rd_total % (2 * DEPTH)));
    endtask

    task automatic step(input bit wr, input bit rd, input logic [DW-1:0] d);
        bit            was_full, was_empty, wacc, racc;
        logic [DW-1:0] popped;
        wr_en = wr;
        rd_en = rd;
        din   = d;
        was_full  = (model_q.size() == DEPTH);
        was_empty = (model_q.size() == 0);
        wacc = wr && !was_full;
        racc = rd && !was_empty;
        popped = '0;
        @(posedge clk);
        if (racc) begin
            popped = model_q.pop_front();
            rd_total++;
        end
        if (wacc) begin
            model_q.push_back(d);
            wr_total++;
        end
        #1;
        txn++;
        $display("txn %0d wr=%b rd=%b din=%02h count=%0d dout_std=%02h/%b dout_fwft=%02h/%b",
                 txn, wr, rd, d, s_count, s_dout, s_valid, f_dout, f_valid);
        check_all(wr && was_full, rd && was_empty, racc, popped);
    endtask

    task automatic do_reset(input bit wr, input bit rd);
        rst   = 1'b1;
        wr_en = wr;
        rd_en = rd;
        din   = 8'h77;
        @(posedge clk);
        model_q.delete();
        wr_total = 0;
        rd_total = 0;
        #1;
        txn++;
        $display("txn %0d reset wr=%b rd=%b count=%0d", txn, wr, rd, s_count);
        check_all(1'b0, 1'b0, 1'b0, '0);
        check_eq("rst_dout_std",  32'(s_dout), 32'h0);
        check_eq("rst_dout_fwft", 32'(f_dout), 32'h0);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;
        do_reset(1'b0, 1'b0);

        // Fill to full, then drain in order.
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 8'(i));
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00);

        // Simultaneous request on a full FIFO: read wins, write dropped.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'($urandom));
        step(1'b1, 1'b1, 8'hEE);
        step(1'b0, 1'b0, 8'h00);
        while (model_q.size() > 0) step(1'b0, 1'b1, 8'h00);

        // Reads on an empty FIFO.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h00);

        // Streaming at constant occupancy across pointer wrap.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'($urandom));
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 8'($urandom));
        while (model_q.size() > 0) step(1'b0, 1'b1, 8'h00);

        // Latency from empty.
        step(1'b1, 1'b0, 8'hA5);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Reset mid-stream discards contents.
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'($urandom));
        do_reset(1'b1, 1'b1);
        step(1'b1, 1'b0, 8'h3C);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 8'h00);

        // Random traffic with shifting write/read bias and occasional reset.
        for (int seg = 0; seg < 6; seg++) begin
            int wbias, rbias;
            wbias = (seg % 2 == 0) ? 80 : 30;
            rbias = (seg % 2 == 0) ? 30 : 80;
            for (int i = 0; i < 60; i++) begin
                if ($urandom_range(0, 99) == 0) begin
                    do_reset(1'($urandom), 1'($urandom));
                end else begin
                    step($urandom_range(0, 99) < wbias, $urandom_range(0, 99) < rbias,
                         8'($urandom));
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
